// File: rtl/pe_array_feeder.sv
// Tile buffer and skewed streamer feeding an NxN systolic PE array (maps left column, weights top row).
// Optional synchronous abort input is compiled in when PE_ARRAY_FEEDER_ABORT_EN is defined.

module pe_array_feeder_lane #(
  parameter int DW    = 16,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  logic [DEPTH-1:0][DW-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (flush_i) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];
endmodule

module pe_array_feeder #(
  parameter int N  = 4,
  parameter int K  = 16,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PE_ARRAY_FEEDER_ABORT_EN
  input  logic              i_abort,
`endif
  input  logic              i_vld,
  output logic              o_rdy,
  input  logic [N*DW-1:0]   i_map_vec,
  input  logic [N*DW-1:0]   i_weight_vec,
  output logic [N*DW-1:0]   o_map_row,
  output logic [N*DW-1:0]   o_weight_col,
  output logic [2*N-2:0]    o_clear_diag,
  output logic              o_busy,
  output logic              o_done
);
  localparam int CW  = $clog2(K + 1);
  localparam int AW  = (K > 1) ? $clog2(K) : 1;
  localparam int DCW = $clog2(2 * N);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   load_cnt_q, load_cnt_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DCW-1:0]  drn_cnt_q, drn_cnt_d;
  logic [2*N-2:0]  clr_q;
  logic [N*DW-1:0] map_mem [K];
  logic [N*DW-1:0] wgt_mem [K];
  logic [N*DW-1:0] map_rd, wgt_rd;
  logic [AW-1:0]   rd_idx;
  logic            xfer, last_beat, rd_en, abort;

`ifdef PE_ARRAY_FEEDER_ABORT_EN
  assign abort = i_abort && (state_q inside {S_LOAD, S_CLEAR, S_STREAM, S_DRAIN});
`else
  assign abort = 1'b0;
`endif

  assign o_rdy     = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign xfer      = i_vld && o_rdy && !abort;
  assign last_beat = xfer && (load_cnt_q == CW'(K - 1));

  // CLEAR always reads beat 0; the stale pointer from the previous tile is ignored there.
  assign rd_en  = (state_q == S_CLEAR) || ((state_q == S_STREAM) && (rd_ptr_q < CW'(K)));
  assign rd_idx = (state_q == S_CLEAR) ? '0 : rd_ptr_q[AW-1:0];
  assign map_rd = rd_en ? map_mem[rd_idx] : '0;
  assign wgt_rd = rd_en ? wgt_mem[rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (xfer) begin
      map_mem[load_cnt_q[AW-1:0]] <= i_map_vec;
      wgt_mem[load_cnt_q[AW-1:0]] <= i_weight_vec;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    drn_cnt_d  = drn_cnt_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (xfer) begin
          load_cnt_d = load_cnt_q + CW'(1);
          state_d    = last_beat ? S_CLEAR : S_LOAD;
        end
      end
      S_CLEAR: begin
        rd_ptr_d = CW'(1);
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        if (rd_ptr_q == CW'(K)) begin
          drn_cnt_d = '0;
          state_d   = S_DRAIN;
        end else begin
          rd_ptr_d = rd_ptr_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (drn_cnt_q == DCW'(2 * N - 2)) state_d = S_DONE;
        else                              drn_cnt_d = drn_cnt_q + DCW'(1);
      end
      S_DONE: begin
        load_cnt_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d    = S_IDLE;
      load_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      rd_ptr_q   <= '0;
      drn_cnt_q  <= '0;
      clr_q      <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      drn_cnt_q  <= drn_cnt_d;
      // Bit 0 fires in the CLEAR cycle, then walks one anti-diagonal per cycle.
      clr_q      <= abort ? '0 : {clr_q[2*N-3:0], last_beat};
    end
  end

  assign o_clear_diag = clr_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);

  // Lane r sits r+1 registers behind the buffer read, giving beat k at C+1+r+k.
  for (genvar r = 0; r < N; r++) begin : g_lane
    pe_array_feeder_lane #(.DW(DW), .DEPTH(r + 1)) u_map (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (abort),
      .d_i     (map_rd[r*DW +: DW]),
      .q_o     (o_map_row[r*DW +: DW])
    );
    pe_array_feeder_lane #(.DW(DW), .DEPTH(r + 1)) u_wgt (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (abort),
      .d_i     (wgt_rd[r*DW +: DW]),
      .q_o     (o_weight_col[r*DW +: DW])
    );
  end
endmodule

// File: tb/tb_pe_array_feeder.sv
// Scoreboard bench for pe_array_feeder: stimulus pushes per-cycle expected output records,
// a negedge monitor aligns on the first clear pulse or o_done and compares every cycle of the tile.
module tb_pe_array_feeder;
  localparam int N  = 4;
  localparam int K  = 16;
  localparam int DW = 16;
  localparam int NJ = K + 2 * N + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            i_vld = 1'b0;
  logic            o_rdy;
  logic [N*DW-1:0] i_map_vec = '0;
  logic [N*DW-1:0] i_weight_vec = '0;
  logic [N*DW-1:0] o_map_row, o_weight_col;
  logic [2*N-2:0]  o_clear_diag;
  logic            o_busy, o_done;
`ifdef PE_ARRAY_FEEDER_ABORT_EN
  logic            i_abort = 1'b0;
`endif

  typedef struct packed {
    logic [N*DW-1:0] map;
    logic [N*DW-1:0] wgt;
    logic [2*N-2:0]  clr;
    logic            done;
  } rec_t;

  rec_t            exp_q[$];
  int              start_q[$];
  int              first_log[$];
  int              last_log[$];
  logic [N*DW-1:0] tmap [K];
  logic [N*DW-1:0] twgt [K];
  int checks = 0, errors = 0, cyc = 0;
  int done_cnt = 0, clr_cnt = 0, last_done_cyc = 0, exp_done = 0;
  bit kill = 1'b0, cap = 1'b0, post = 1'b0;
  int j = 0;

  pe_array_feeder #(.N(N), .K(K), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef PE_ARRAY_FEEDER_ABORT_EN
    .i_abort      (i_abort),
`endif
    .i_vld        (i_vld),
    .o_rdy        (o_rdy),
    .i_map_vec    (i_map_vec),
    .i_weight_vec (i_weight_vec),
    .o_map_row    (o_map_row),
    .o_weight_col (o_weight_col),
    .o_clear_diag (o_clear_diag),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rec_t e;
    int   s;
    if (o_done) begin done_cnt++; last_done_cyc = cyc; end
    if (o_clear_diag != '0) clr_cnt++;
    if (!rst_n || kill) begin
      cap = 1'b0; post = 1'b0;
    end else begin
      if (post) begin
        checks++;
        if (o_busy !== 1'b0 || o_rdy !== 1'b1) begin
          errors++;
          $display("FAIL idle_after_done busy=%0b rdy=%0b want busy=0 rdy=1", o_busy, o_rdy);
        end
        post = 1'b0;
      end
      if (!cap && (o_clear_diag[0] || o_done)) begin
        checks++;
        if (start_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tile cyc=%0d clr=%b done=%0b want no activity", cyc, o_clear_diag, o_done);
        end else begin
          s = start_q.pop_front();
          cap = 1'b1; j = 0;
          if (cyc != s) begin
            errors++;
            $display("FAIL clear_start_cycle got %0d want %0d", cyc, s);
          end
        end
      end
      if (cap) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; cap = 1'b0;
          $display("FAIL scoreboard_empty cyc=%0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({o_map_row, o_weight_col, o_clear_diag, o_done} !== e || o_rdy !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL tile_out j=%0d map=%h wgt=%h clr=%b done=%0b rdy=%0b busy=%0b want map=%h wgt=%h clr=%b done=%0b rdy=0 busy=1",
                     j, o_map_row, o_weight_col, o_clear_diag, o_done, o_rdy, o_busy, e.map, e.wgt, e.clr, e.done);
          end
          j++;
          if (j == NJ) begin cap = 1'b0; post = 1'b1; end
        end
      end
    end
  end

  function automatic logic [DW-1:0] bval(input int pat, input int t, input int k, input int lane, input bit w);
    case (pat)
      0:       return 16'h0100;
      1:       return w ? 16'h0100 : DW'(k);
      default: return w ? DW'(32'h8000 + lane * 256 + t * 16 + k) : DW'(lane * 4096 + t * 256 + k);
    endcase
  endfunction

  task automatic push_tile(input int l);
    rec_t e;
    int   b;
    start_q.push_back(l + 1);
    for (int jj = 0; jj < NJ; jj++) begin
      e = '0;
      for (int r = 0; r < N; r++) begin
        b = jj - 1 - r;
        if (b >= 0 && b < K) begin
          e.map[r*DW +: DW] = tmap[b][r*DW +: DW];
          e.wgt[r*DW +: DW] = twgt[b][r*DW +: DW];
        end
      end
      if (jj < 2 * N - 1) e.clr[jj] = 1'b1;
      e.done = (jj == NJ - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input int ntiles, input int pat, input bit toggle);
    int acc, g, t, k;
    acc = 0; g = 0;
    first_log.delete(); last_log.delete();
    while (acc < ntiles * K && g < 4000) begin
      @(posedge clk); #1;
      t = acc / K; k = acc % K;
      if (toggle && (g % 2 == 1)) begin
        i_vld = 1'b0;
        i_map_vec = {N{16'hBAD0}};
        i_weight_vec = {N{16'hBAD1}};
      end else begin
        i_vld = 1'b1;
        for (int r = 0; r < N; r++) begin
          i_map_vec[r*DW +: DW]    = bval(pat, t, k, r, 1'b0);
          i_weight_vec[r*DW +: DW] = bval(pat, t, k, r, 1'b1);
        end
      end
      @(negedge clk);
      if (i_vld && o_rdy) begin
        tmap[k] = i_map_vec;
        twgt[k] = i_weight_vec;
        if (k == 0) first_log.push_back(cyc);
        if (k == K - 1) begin
          last_log.push_back(cyc);
          push_tile(cyc);
          exp_done++;
        end
        acc++;
      end
      g++;
    end
    checks++;
    if (acc < ntiles * K) begin
      errors++;
      $display("FAIL send_timeout accepted=%0d want %0d", acc, ntiles * K);
    end
    @(posedge clk); #1;
    i_vld = 1'b0; i_map_vec = '0; i_weight_vec = '0;
  endtask

  task automatic wait_done(input string nm);
    int g;
    g = 0;
    while (done_cnt < exp_done && g < 300) begin @(posedge clk); g++; end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != exp_done) begin
      errors++;
      $display("FAIL %s done_count got %0d want %0d", nm, done_cnt, exp_done);
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({o_map_row, o_weight_col, o_clear_diag, o_done, o_busy} !== '0) begin
      errors++;
      $display("FAIL %s map=%h wgt=%h clr=%b done=%0b busy=%0b want all 0", nm, o_map_row, o_weight_col, o_clear_diag, o_done, o_busy);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    int d0, c0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    check_int("idle_rdy_after_reset", int'(o_rdy), 1);

    // T1: unit data back-to-back; o_done 1+K+(2N-1)+1 cycles after the last beat
    send(1, 0, 1'b0);
    wait_done("t1");
    check_int("t1_done_latency", last_done_cyc - last_log[0], K + 2 * N + 1);

    // T2: map lane = beat index
    send(1, 1, 1'b0);
    wait_done("t2");

    // T3: i_vld toggling during LOAD
    send(1, 0, 1'b1);
    wait_done("t3");

    // T4: i_vld held across two tiles; second tile starts in the IDLE cycle after DONE
    send(2, 0, 1'b0);
    wait_done("t4");
    check_int("t4_second_first_beat", first_log[1], last_log[0] + K + 2 * N + 2);

    // distinct per-lane data to catch lane swaps
    send(1, 2, 1'b0);
    wait_done("lanes");

    // T5: reset in STREAM cycle C+5
    send(1, 2, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    kill = 1'b1; exp_q.delete(); start_q.delete();
    d0 = done_cnt; c0 = clr_cnt;
    rst_n = 1'b0;
    exp_done--;
    #1;
    check_zero("t5_reset_mid_stream");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; kill = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_int("t5_no_done", done_cnt, d0);
    check_int("t5_no_clear", clr_cnt, c0);
    send(1, 0, 1'b0);
    wait_done("t5_fresh");

`ifdef PE_ARRAY_FEEDER_ABORT_EN
    // T6: abort in DRAIN (cycle C+18) while lane 3 still holds beat 15
    send(1, 2, 1'b0);
    repeat (18) @(posedge clk);
    #1 i_abort = 1'b1;
    @(posedge clk);
    #1;
    i_abort = 1'b0; kill = 1'b1; exp_q.delete(); start_q.delete();
    exp_done--;
    d0 = done_cnt;
    check_zero("t6_abort_outputs");
    check_int("t6_abort_rdy", int'(o_rdy), 1);
    @(posedge clk);
    #1 kill = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_int("t6_no_done", done_cnt, d0);
    send(1, 1, 1'b0);
    wait_done("t6_after");
`endif

    check_int("queues_drained", exp_q.size() + start_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
